// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch/decode constants, queue entry type and J-immediate helper
package fetch_unit_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO of fetched {pc, instr} entries
//   clk_i, rst_ni      clock, async active-low reset
//   push_i, entry_i    write an entry (caller guarantees not full)
//   pop_i              drop the head (caller guarantees not empty)
//   flush_i            discard all entries; overrides push/pop
//   head_o, count_o, empty_o  head entry, occupancy, empty flag
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int AW = $clog2(QDEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [AW:0]  count_o,
  output logic         empty_o
);
  fetch_entry_t mem_q [QDEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end

  always_ff @(posedge clk_i)
    if (push_i && !flush_i) mem_q[wr_q] <= entry_i;

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder
//   CLK, RSTN                  clock, async active-low reset
//   STALL, REDIRECT(_PC)       downstream hold; flush and refetch from a new address
//   IMEM_REQ/ADDR/READY        word request channel (accepted on REQ & READY)
//   IMEM_RVALID/RDATA          in-order responses
//   DECODER_ENABLED            head consumed this cycle
//   INSTRUCTION, PC            head word and its address (NOP / 0 when empty)
// Optional: FETCH_JAL_PREDECODE_EN redirects fetch on a queued JAL.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        DECODER_ENABLED,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(QDEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [AW:0] out_q, out_d, drop_q, drop_d, count;
  logic [AW+1:0] used;
  logic empty, accept, push;
  fetch_entry_t head;

  // Queued plus in-flight words never exceed the queue depth, so a push always fits.
  assign used            = {1'b0, count} + {1'b0, out_q};
  assign IMEM_REQ        = RSTN & !REDIRECT & (used < DEPTH_W);
  assign IMEM_ADDR       = fetch_pc_q;
  assign accept          = IMEM_REQ & IMEM_READY;
  assign DECODER_ENABLED = !empty & !STALL & !REDIRECT;
  assign INSTRUCTION     = empty ? NOP_INSTR : head.instr;
  assign PC              = empty ? '0 : head.pc;

  always_comb begin
    fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    out_d      = out_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, IMEM_RVALID};
    push       = 1'b0;
    if (IMEM_RVALID) begin
      if (drop_q != '0) drop_d = drop_q - 1'b1;
      else begin
        push      = 1'b1;
        resp_pc_d = resp_pc_q + 32'd4;
`ifdef FETCH_JAL_PREDECODE_EN
        // Everything still in flight after this cycle was issued behind the JAL.
        if (IMEM_RDATA[6:0] == OPC_JAL) begin
          fetch_pc_d = (resp_pc_q + j_imm(IMEM_RDATA)) & ~32'h3;
          resp_pc_d  = fetch_pc_d;
          drop_d     = out_d;
        end
`endif
      end
    end
    // No request is issued while redirecting, so out_d is exactly the in-flight words to discard.
    if (REDIRECT) begin
      push       = 1'b0;
      fetch_pc_d = REDIRECT_PC & ~32'h3;
      resp_pc_d  = fetch_pc_d;
      drop_d     = out_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .push_i  (push),
    .entry_i ('{pc: resp_pc_q, instr: IMEM_RDATA}),
    .pop_i   (DECODER_ENABLED),
    .flush_i (REDIRECT),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );
endmodule
